// File: rtl/wdt_counter.sv
// -----------------------------------------------------------------------------
// wdt_counter
//   Watchdog-style up-counter with a programmable prescaler, a kick/reload
//   handshake and a wrap detector. All pulse outputs come straight from flops.
//
// Ports
//   clk_i       : single clock, rising edge
//   rst_i       : asynchronous active-high reset
//   enable_i    : runs the watchdog while high
//   presc_i     : one count tick per presc_i+1 RUN clocks
//   reload_i    : start/kick value for the counter
//   kick_req_i  : service request (honoured in RUN, and in HOLD when disabled)
//   kick_ack_o  : one-cycle acknowledge, one clock after the request
//   counter_o   : present counter value
//   tick_o      : one-cycle pulse on each counter increment
//   wrap_o      : one-cycle pulse when the counter wraps 0xFFFF_FFFF -> 0
//   state_o     : IDLE=0, LOAD=1, RUN=2, HOLD=3
// -----------------------------------------------------------------------------
module wdt_counter #(
  parameter int PRESC_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               enable_i,
  input  logic [PRESC_W-1:0] presc_i,
  input  logic [31:0]        reload_i,
  input  logic               kick_req_i,
  output logic               kick_ack_o,
  output logic [31:0]        counter_o,
  output logic               tick_o,
  output logic               wrap_o,
  output logic [1:0]         state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t             r_state;
  logic [PRESC_W-1:0] r_cnt;
  logic [31:0]        r_counter;
  logic               r_tick;
  logic               r_wrap;
  logic               r_ack;

  // ">=" rather than "==" so that lowering presc_i below the running count
  // ticks immediately instead of waiting for the prescaler to roll over.
  logic               w_tick_due;
  logic [31:0]        w_counter_inc;

  assign w_tick_due    = (r_cnt >= presc_i);
  assign w_counter_inc = r_counter + 32'd1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_counter <= '0;
      r_tick    <= 1'b0;
      r_wrap    <= 1'b0;
      r_ack     <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
      r_ack  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Load on entry so counter_o already shows reload_i during LOAD.
          if (enable_i) begin
            r_state   <= S_LOAD;
            r_counter <= reload_i;
            r_cnt     <= '0;
          end
        end
        S_LOAD: begin
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (kick_req_i) begin
            // Kick beats a coincident tick: no tick/wrap this cycle.
            r_counter <= reload_i;
            r_cnt     <= '0;
            r_ack     <= 1'b1;
            if (!enable_i) r_state <= S_HOLD;
          end else if (!enable_i) begin
            r_state <= S_HOLD;
          end else if (w_tick_due) begin
            r_cnt     <= '0;
            r_counter <= w_counter_inc;
            r_tick    <= 1'b1;
            r_wrap    <= (w_counter_inc == 32'd0);
          end else begin
            r_cnt <= r_cnt + PRESC_W'(1);
          end
        end
        S_HOLD: begin
          // Counter and prescaler phase are frozen here.
          if (enable_i) begin
            r_state <= S_RUN;
          end else if (kick_req_i) begin
            r_ack   <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign kick_ack_o = r_ack;
  assign counter_o  = r_counter;
  assign tick_o     = r_tick;
  assign wrap_o     = r_wrap;
  assign state_o    = r_state;

endmodule

// File: tb/tb_wdt_counter.sv
// -----------------------------------------------------------------------------
// tb_wdt_counter
//   Directed scenarios followed by a randomized run, all checked against a
//   behavioural model of the watchdog kept in plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_wdt_counter;
  localparam int PW = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          enable_i;
  logic [PW-1:0] presc_i;
  logic [31:0]   reload_i;
  logic          kick_req_i;
  logic          kick_ack_o;
  logic [31:0]   counter_o;
  logic          tick_o;
  logic          wrap_o;
  logic [1:0]    state_o;

  wdt_counter #(.PRESC_W(PW)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .enable_i   (enable_i),
    .presc_i    (presc_i),
    .reload_i   (reload_i),
    .kick_req_i (kick_req_i),
    .kick_ack_o (kick_ack_o),
    .counter_o  (counter_o),
    .tick_o     (tick_o),
    .wrap_o     (wrap_o),
    .state_o    (state_o)
  );

  always #5 clk_i = ~clk_i;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: mode name as a small integer, counts as wide integers.
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_HOLD = 3;
  localparam longint TWO32 = 64'd1 << 32;
  int     m_mode;
  longint m_phase;
  longint m_count;
  bit     m_tick, m_wrap, m_ack;

  task automatic model_reset();
    m_mode = M_IDLE; m_phase = 0; m_count = 0;
    m_tick = 0; m_wrap = 0; m_ack = 0;
  endtask

  // Applies one rising edge worth of the watchdog rules to the model.
  task automatic model_edge();
    m_tick = 0; m_wrap = 0; m_ack = 0;
    if (m_mode == M_IDLE) begin
      if (enable_i) begin
        m_mode = M_LOAD; m_count = reload_i; m_phase = 0;
      end
    end else if (m_mode == M_LOAD) begin
      m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (kick_req_i) begin
        m_count = reload_i; m_phase = 0; m_ack = 1;
        if (!enable_i) m_mode = M_HOLD;
      end else if (!enable_i) begin
        m_mode = M_HOLD;
      end else if (m_phase >= longint'(presc_i)) begin
        m_phase = 0;
        m_count = (m_count + 1) % TWO32;
        m_tick  = 1;
        m_wrap  = (m_count == 0);
      end else begin
        m_phase = m_phase + 1;
      end
    end else begin
      if (enable_i) m_mode = M_RUN;
      else if (kick_req_i) begin
        m_ack = 1; m_mode = M_IDLE;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".state"},   {30'd0, state_o},   32'(m_mode));
    chk({tag, ".counter"}, counter_o,          32'(m_count));
    chk({tag, ".tick"},    {31'd0, tick_o},    {31'd0, m_tick});
    chk({tag, ".wrap"},    {31'd0, wrap_o},    {31'd0, m_wrap});
    chk({tag, ".ack"},     {31'd0, kick_ack_o},{31'd0, m_ack});
  endtask

  // One clock: model advances on the edge, DUT sampled 1 ns later.
  task automatic step(input string tag);
    @(posedge clk_i);
    if (!rst_i) model_edge();
    #1;
    chk_model(tag);
  endtask

  // Pulse reset between edges (called at posedge+1) and check it took effect
  // before the next edge.
  task automatic pulse_reset(input string tag);
    #2 rst_i = 1'b1;
    #1;
    model_reset();
    chk_model(tag);
    chk({tag, ".zero_counter"}, counter_o, 32'd0);
    chk({tag, ".zero_state"},   {30'd0, state_o}, 32'd0);
    #1 rst_i = 1'b0;
  endtask

  int ticks;

  initial begin
    rst_i = 1'b1; enable_i = 1'b0; presc_i = '0; reload_i = '0; kick_req_i = 1'b0;
    model_reset();
    #12;
    chk_model("reset");
    rst_i = 1'b0;

    // Wrap sequence with presc=0
    enable_i = 1'b1; presc_i = '0; reload_i = 32'hFFFF_FFFD;
    step("wrap.load");
    chk("wrap.load_state", {30'd0, state_o}, 32'd1);
    chk("wrap.load_value", counter_o, 32'hFFFF_FFFD);
    step("wrap.run0");
    step("wrap.fe");
    chk("wrap.fe_value", counter_o, 32'hFFFF_FFFE);
    step("wrap.ff");
    chk("wrap.ff_nowrap", {31'd0, wrap_o}, 32'd0);
    step("wrap.zero");
    chk("wrap.zero_value", counter_o, 32'd0);
    chk("wrap.zero_pulse", {31'd0, wrap_o}, 32'd1);
    step("wrap.after");

    // presc=3: tick every 4th RUN cycle
    pulse_reset("rst2");
    presc_i = 16'd3; reload_i = 32'h10;
    step("p3.load");
    step("p3.run0");
    for (int i = 0; i < 4; i++) step("p3.run");
    chk("p3.counter_11", counter_o, 32'h11);
    chk("p3.tick", {31'd0, tick_o}, 32'd1);
    ticks = 0;
    for (int i = 0; i < 8; i++) begin
      step("p3.more");
      if (tick_o) ticks++;
    end
    chk("p3.tick_rate", 32'(ticks), 32'd2);

    // Kick on the cycle a tick is due
    for (int i = 0; i < 3; i++) step("kick.pre");
    kick_req_i = 1'b1; reload_i = 32'h100;
    step("kick.due");
    chk("kick.counter", counter_o, 32'h100);
    chk("kick.ack", {31'd0, kick_ack_o}, 32'd1);
    chk("kick.no_tick", {31'd0, tick_o}, 32'd0);
    chk("kick.no_wrap", {31'd0, wrap_o}, 32'd0);
    for (int i = 0; i < 3; i++) step("kick.held");
    kick_req_i = 1'b0;
    step("kick.release");
    chk("kick.ack_drop", {31'd0, kick_ack_o}, 32'd0);

    // Prescaler lowered below the running count ticks at once
    presc_i = 16'd6;
    for (int i = 0; i < 12 && !(m_mode == M_RUN && m_phase == 5); i++) step("pchg.wait");
    presc_i = 16'd2;
    step("pchg.tick");
    chk("pchg.tick_now", {31'd0, tick_o}, 32'd1);

    // HOLD freezes value and prescaler phase
    pulse_reset("rst3");
    presc_i = 16'd1; reload_i = 32'h1E;
    for (int i = 0; i < 40 && !(m_count == 32'h20 && m_phase == 1); i++) step("hold.wait");
    chk("hold.reached_20", counter_o, 32'h20);
    enable_i = 1'b0;
    for (int i = 0; i < 4; i++) step("hold.frozen");
    chk("hold.state", {30'd0, state_o}, 32'd3);
    chk("hold.value", counter_o, 32'h20);
    enable_i = 1'b1;
    step("hold.resume");
    step("hold.phase");
    chk("hold.phase_tick", {31'd0, tick_o}, 32'd1);
    chk("hold.phase_value", counter_o, 32'h21);

    // Kick in HOLD with enable low -> IDLE, value kept
    enable_i = 1'b0;
    step("hk.hold");
    kick_req_i = 1'b1; reload_i = 32'h55;
    step("hk.kick");
    chk("hk.ack", {31'd0, kick_ack_o}, 32'd1);
    chk("hk.idle", {30'd0, state_o}, 32'd0);
    chk("hk.value", counter_o, 32'h21);

    // Kick in IDLE ignored
    step("ik.1");
    step("ik.2");
    chk("ik.no_ack", {31'd0, kick_ack_o}, 32'd0);
    chk("ik.value", counter_o, 32'h21);
    kick_req_i = 1'b0;

    // Reload of zero does not wrap
    reload_i = 32'd0; enable_i = 1'b1;
    step("z.load");
    chk("z.no_wrap", {31'd0, wrap_o}, 32'd0);
    step("z.run");

    // Asynchronous reset mid-RUN, then first enabled edge enters LOAD
    presc_i = 16'd0; reload_i = 32'h1234;
    for (int i = 0; i < 3; i++) step("ar.run");
    pulse_reset("ar.reset");
    chk("ar.no_tick", {31'd0, tick_o}, 32'd0);
    step("ar.first");
    chk("ar.first_load", {30'd0, state_o}, 32'd1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      enable_i   = ($urandom_range(0, 9) != 0);
      kick_req_i = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) presc_i = PW'($urandom_range(0, 4));
      if ($urandom_range(0, 19) == 0)
        reload_i = $urandom_range(0, 1) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : 32'($urandom);
      if ($urandom_range(0, 199) == 0) pulse_reset("rnd.reset");
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wdt_counter.md
WDT_COUNTER -- requirements
Module: wdt_counter

Interface
REQ-001 SHALL have parameter PRESC_W, default 16, meaning the prescaler compare width in bits.
REQ-002 SHALL have port clk_i, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit, the reset; asynchronous and active-high.
REQ-004 SHALL have port enable_i, input, 1 bit, level that runs the watchdog.
REQ-005 SHALL have port presc_i, input, PRESC_W bits, giving one count tick per presc_i+1 clocks.
REQ-006 SHALL have port reload_i, input, 32 bits, the counter start/kick value.
REQ-007 SHALL have port kick_req_i, input, 1 bit, the service request.
REQ-008 SHALL have port kick_ack_o, output, 1 bit, a one-cycle kick acknowledge.
REQ-009 SHALL have port counter_o, output, 32 bits, the present counter value, fed to the overflow detector.
REQ-010 SHALL have port tick_o, output, 1 bit, a one-cycle pulse on each counter increment.
REQ-011 SHALL have port wrap_o, output, 1 bit, a one-cycle pulse when the counter wraps 0xFFFF_FFFF to 0.
REQ-012 SHALL have port state_o, output, 2 bits, the FSM state: IDLE=0, LOAD=1, RUN=2, HOLD=3.

Function
REQ-013 SHALL implement FSM IDLE -> LOAD when enable_i=1; LOAD -> RUN unconditionally after 1 cycle; RUN -> HOLD when enable_i=0; HOLD -> RUN when enable_i=1; HOLD -> IDLE when kick_req_i=1 with enable_i=0.
REQ-014 In LOAD: SHALL set counter_o=reload_i and prescaler count=0, with no tick_o.
REQ-015 In RUN: SHALL increment the prescaler count each cycle; at count==presc_i it SHALL clear to 0, assert tick_o and increment counter_o by 1, modulo 2^32.
REQ-016 presc_i=0 SHALL produce a tick every RUN cycle.
REQ-017 A change of presc_i in RUN SHALL take effect at the next compare.
REQ-018 If the count exceeds the new presc_i, the count SHALL tick and clear at once.
REQ-019 wrap_o SHALL assert in the same cycle counter_o becomes 0x0000_0000 by increment.
REQ-020 Loading reload_i=0 SHALL NOT assert wrap_o.
REQ-021 kick_req_i in RUN SHALL load counter_o=reload_i and clear the prescaler count on the next edge.
REQ-022 kick_ack_o SHALL be 1 for exactly that cycle, with latency 1 clock from the request.
REQ-023 A kick held high SHALL re-kick and re-ack every cycle.
REQ-024 If a kick and a tick coincide, the kick SHALL win: no tick_o and no wrap_o that cycle.
REQ-025 In HOLD: counter_o and the prescaler count SHALL freeze, with no tick.
REQ-026 A kick in HOLD with enable_i=0 SHALL ack and go to IDLE, leaving counter_o unchanged.
REQ-027 In IDLE: counter_o SHALL hold its value, and tick_o, wrap_o and kick_ack_o SHALL be 0.
REQ-028 A kick in IDLE or LOAD SHALL be ignored (no ack).
REQ-029 tick_o, wrap_o and kick_ack_o SHALL be registered outputs, glitch-free.

Reset
REQ-030 On rst_i=1, asynchronously: state=IDLE, counter_o=0, prescaler count=0, and tick_o=wrap_o=kick_ack_o=0.
REQ-031 Reset asserted mid-RUN SHALL abort immediately.
REQ-032 After rst_i deasserts, the first active edge with enable_i=1 SHALL enter LOAD.

Verification
REQ-033 SHALL cover: reset, enable=1, presc=0, reload=0xFFFF_FFFD -> LOAD then counter 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0; wrap_o=1 only with 0x0.
REQ-034 SHALL cover: presc=3, reload=0x10 -> tick_o every 4th cycle; counter 0x11 after 4 RUN cycles.
REQ-035 SHALL cover: kick on the cycle a tick is due, reload=0x100 -> counter=0x100, kick_ack_o=1, tick_o=0, wrap_o=0.
REQ-036 SHALL cover: enable drops at counter=0x20 -> HOLD; counter stays 0x20; enable=1 resumes counting from 0x20 with the same prescaler phase.
REQ-037 SHALL cover: rst_i pulsed asynchronously mid-RUN, between edges -> all outputs 0 and state_o=0 before the next clock edge.
REQ-038 SHALL cover: kick while IDLE -> kick_ack_o stays 0 and counter_o unchanged.
